fp_rnd_arb: RTL

Shares one `fp_rnd` rounding instance between up to `NREQ` unrounded-result producers (FMA, div/sqrt, conversion units), so the FPU needs a single rounder. It arbitrates round-robin with a valid/ready handshake per requester. It registers the granted payload before `fp_rnd` and registers the rounded result after it, tagged with the requester ID. It also keeps a sticky accumulated exception-flag register for the CSR block.

---
 rtl/fp_rnd_arb.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fp_rnd_arb.sv
// Round-robin front end that shares one fp_rnd rounder between NREQ producers.
// Payload is registered before the rounder and the tagged result after it.

package fp_rnd_pkg;

  typedef struct packed {
    logic        sig;
    logic [9:0]  expo;
    logic [24:0] mant;
    logic [1:0]  rema;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [2:0]  grs;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        infs;
    logic        zero;
    logic        diff;
  } fp_rnd_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
  } fp_rnd_out_type;

endpackage

module fp_rnd_arb
  import fp_rnd_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic          [NREQ-1:0]       req_valid,
  input  fp_rnd_in_type [NREQ-1:0]       req_data,
  output logic          [NREQ-1:0]       req_ready,
  output fp_rnd_in_type                  rnd_i,
  input  fp_rnd_out_type                 rnd_o,
  output logic                           res_valid,
  output logic          [IDW-1:0]        res_id,
  output logic          [31:0]           res_result,
  output logic          [4:0]            res_flags,
  input  logic                           res_ready,
  input  logic                           flags_clr,
  output logic          [4:0]            acc_flags
);

  // Returns {found, index} of the first valid requester scanning from ptr.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                           input logic [IDW-1:0]  ptr);
    logic           found;
    logic [IDW-1:0] id;
    int             idx;
    found = 1'b0;
    id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k >= NREQ) ? int'(ptr) + k - NREQ : int'(ptr) + k;
      if (!found && vld[idx]) begin
        found = 1'b1;
        id    = IDW'(idx);
      end else begin
        found = found;
      end
    end
    return {found, id};
  endfunction

  logic           s1_valid_q, s1_valid_d;
  logic [IDW-1:0] s1_id_q,    s1_id_d;
  fp_rnd_in_type  s1_data_q,  s1_data_d;
  logic           res_valid_q, res_valid_d;
  logic [IDW-1:0] res_id_q,    res_id_d;
  logic [31:0]    res_result_q, res_result_d;
  logic [4:0]     res_flags_q,  res_flags_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [4:0]     acc_flags_q, acc_flags_d;

  logic           s2_en_s;
  logic           s1_en_s;
  logic           win_found_s;
  logic [IDW-1:0] win_id_s;
  logic           grant_s;

  // Arbitration, grant and next-state for both pipeline stages and flags.
  always_comb begin
    s2_en_s      = ~res_valid_q | res_ready;
    s1_en_s      = ~s1_valid_q | s2_en_s;
    {win_found_s, win_id_s} = rr_pick(req_valid, rr_q);
    grant_s      = s1_en_s & win_found_s & ~reset;

    req_ready    = '0;
    s1_valid_d   = s1_valid_q;
    s1_id_d      = s1_id_q;
    s1_data_d    = s1_data_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_result_d = res_result_q;
    res_flags_d  = res_flags_q;
    rr_d         = rr_q;

    if (grant_s) begin
      req_ready[win_id_s] = 1'b1;
      s1_id_d   = win_id_s;
      s1_data_d = req_data[win_id_s];
      rr_d      = (win_id_s == IDW'(NREQ - 1)) ? '0 : win_id_s + IDW'(1);
    end else begin
      rr_d      = rr_q;
    end

    if (s1_en_s) begin
      s1_valid_d = grant_s;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_en_s) begin
      res_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_id_d     = s1_id_q;
        res_result_d = rnd_o.result;
        res_flags_d  = rnd_o.flags;
      end else begin
        res_id_d     = res_id_q;
      end
    end else begin
      res_valid_d = res_valid_q;
    end

    // A clear coinciding with a handshake keeps the freshly accepted flags.
    acc_flags_d = (flags_clr ? 5'b00000 : acc_flags_q)
                | ((res_valid_q & res_ready) ? res_flags_q : 5'b00000);
  end

  // Pipeline, pointer and sticky-flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      s1_data_q    <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_result_q <= 32'h0000_0000;
      res_flags_q  <= 5'b00000;
      rr_q         <= '0;
      acc_flags_q  <= 5'b00000;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      s1_data_q    <= s1_data_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_result_q <= res_result_d;
      res_flags_q  <= res_flags_d;
      rr_q         <= rr_d;
      acc_flags_q  <= acc_flags_d;
    end
  end

  assign rnd_i      = s1_data_q;
  assign res_valid  = res_valid_q;
  assign res_id     = res_id_q;
  assign res_result = res_result_q;
  assign res_flags  = res_flags_q;
  assign acc_flags  = acc_flags_q;

endmodule
